temperature_sequencer: RTL and testbench

TEMPERATURE_SEQUENCER -- requirements
Module: temperature_sequencer

---
 rtl/temperature_pkg.sv | 16 +
 rtl/seq_divider.sv | 76 +++++++
 rtl/temperature_sequencer.sv | 156 +++++++++++++++
 tb/tb_temperature_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/temperature_pkg.sv
// Shared constants and FSM encoding for the temperature averaging sequencer
// and its datapath helpers.
package temperature_pkg;

    localparam int NUM_SENSORS = 5;
    localparam int DATA_W      = 8;
    localparam int SUM_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, W steps.
// done_o flags the final step; quotient_o/remainder_o carry that step's result.
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_r;
    logic [W-1:0]     quo_r;
    logic [W-1:0]     div_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [W:0]       trial_s;
    logic [W-1:0]     diff_s;
    logic [W-1:0]     rem_next_s;
    logic [W-1:0]     quo_next_s;

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial_s = {rem_r, quo_r[W-1]};
        // The difference is only kept when it is below the divisor, so W bits suffice.
        diff_s  = trial_s[W-1:0] - div_r;
        if (trial_s >= {1'b0, div_r}) begin
            rem_next_s = diff_s;
            quo_next_s = {quo_r[W-2:0], 1'b1};
        end else begin
            rem_next_s = trial_s[W-1:0];
            quo_next_s = {quo_r[W-2:0], 1'b0};
        end
    end

    // Operand load on start, then W iteration steps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_r  <= {W{1'b0}};
            quo_r  <= {W{1'b0}};
            div_r  <= {W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start_i && !busy_r) begin
            rem_r  <= {W{1'b0}};
            quo_r  <= dividend_i;
            div_r  <= divisor_i;
            cnt_r  <= CNT_W'(W);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = busy_r && (cnt_r == CNT_W'(1));
    assign quotient_o  = quo_next_s;
    assign remainder_o = rem_next_s;

endmodule

// File: rtl/temperature_sequencer.sv
// Averages the enabled sensor readings: snapshot, serial scan/accumulate,
// then iterative division of the sum by the number of active sensors.
module temperature_sequencer #(
    parameter int NUM_SENSORS = temperature_pkg::NUM_SENSORS,
    parameter int DATA_W      = temperature_pkg::DATA_W,
    parameter int SUM_W       = temperature_pkg::SUM_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [NUM_SENSORS*DATA_W-1:0] sensors_data_i,
    input  logic [NUM_SENSORS-1:0]        sensors_en_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [SUM_W-1:0]              avg_q_o,
    output logic [SUM_W-1:0]              avg_r_o,
    output logic [7:0]                    nr_active_o,
    output logic                          err_no_sensor_o
);
    import temperature_pkg::*;

    localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SENSORS - 1);

    seq_state_t                    state_r;
    logic [IDX_W-1:0]              idx_r;
    logic [SUM_W-1:0]              sum_r;
    logic [7:0]                    count_r;
    logic [NUM_SENSORS*DATA_W-1:0] data_snap_r;
    logic [NUM_SENSORS-1:0]        en_snap_r;
    logic                          busy_r;
    logic                          done_r;
    logic [SUM_W-1:0]              avg_q_r;
    logic [SUM_W-1:0]              avg_r_r;
    logic [7:0]                    nr_active_r;
    logic                          err_r;

    logic [DATA_W-1:0]             cur_data_s;
    logic                          cur_en_s;
    logic [SUM_W-1:0]              sum_next_s;
    logic [7:0]                    count_next_s;
    logic                          last_idx_s;
    logic                          div_start_s;
    logic                          div_busy_s;
    logic                          div_done_s;
    logic [SUM_W-1:0]              div_q_s;
    logic [SUM_W-1:0]              div_r_s;

    // Select the snapshot reading at the scan index and form the next sum/count.
    always_comb begin
        cur_data_s = {DATA_W{1'b0}};
        cur_en_s   = 1'b0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            cur_data_s = (idx_r == IDX_W'(k)) ? data_snap_r[k*DATA_W +: DATA_W] : cur_data_s;
            cur_en_s   = (idx_r == IDX_W'(k)) ? en_snap_r[k] : cur_en_s;
        end
        sum_next_s   = sum_r + (cur_en_s ? SUM_W'(cur_data_s) : {SUM_W{1'b0}});
        count_next_s = count_r + {7'd0, cur_en_s};
        last_idx_s   = (idx_r == LAST_IDX);
        // The divider is fed the final sum/count in the same cycle as the last scan step.
        div_start_s  = (state_r == ST_SCAN) && last_idx_s && (count_next_s != 8'd0);
    end

    seq_divider #(
        .W (SUM_W)
    ) u_divider (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start_s),
        .dividend_i  (sum_next_s),
        .divisor_i   (SUM_W'(count_next_s)),
        .busy_o      (div_busy_s),
        .done_o      (div_done_s),
        .quotient_o  (div_q_s),
        .remainder_o (div_r_s)
    );

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            sum_r       <= {SUM_W{1'b0}};
            count_r     <= 8'd0;
            data_snap_r <= {(NUM_SENSORS*DATA_W){1'b0}};
            en_snap_r   <= {NUM_SENSORS{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            avg_q_r     <= {SUM_W{1'b0}};
            avg_r_r     <= {SUM_W{1'b0}};
            nr_active_r <= 8'd0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        data_snap_r <= sensors_data_i;
                        en_snap_r   <= sensors_en_i;
                        sum_r       <= {SUM_W{1'b0}};
                        count_r     <= 8'd0;
                        idx_r       <= {IDX_W{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    sum_r   <= sum_next_s;
                    count_r <= count_next_s;
                    if (!last_idx_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end else if (count_next_s == 8'd0) begin
                        avg_q_r     <= {SUM_W{1'b0}};
                        avg_r_r     <= {SUM_W{1'b0}};
                        nr_active_r <= 8'd0;
                        err_r       <= 1'b1;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done_s) begin
                        avg_q_r     <= div_q_s;
                        avg_r_r     <= div_r_s;
                        nr_active_r <= count_r;
                        err_r       <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (!div_busy_s) begin
                        // Divider lost its operation: abandon the pass rather than hang.
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign avg_q_o         = avg_q_r;
    assign avg_r_o         = avg_r_r;
    assign nr_active_o     = nr_active_r;
    assign err_no_sensor_o = err_r;

endmodule

// File: tb/tb_temperature_sequencer.sv
// Scoreboard bench for temperature_sequencer: directed passes push expected
// results; a monitor pops and compares on every done_o pulse.
module tb_temperature_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [39:0] sensors_data_i;
    logic [4:0]  sensors_en_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] avg_q_o;
    logic [15:0] avg_r_o;
    logic [7:0]  nr_active_o;
    logic        err_no_sensor_o;

    typedef struct {
        int q;
        int r;
        int nr;
        int err;
        int cyc;
        int start_edge;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   edge_cnt   = 0;
    int   done_seen  = 0;

    temperature_sequencer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .sensors_data_i  (sensors_data_i),
        .sensors_en_i    (sensors_en_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .avg_q_o         (avg_q_o),
        .avg_r_o         (avg_r_o),
        .nr_active_o     (nr_active_o),
        .err_no_sensor_o (err_no_sensor_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            exp_t e;
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", done_seen, 0);
            end else begin
                e = exp_q.pop_front();
                check("avg_q", int'(avg_q_o), e.q);
                check("avg_r", int'(avg_r_o), e.r);
                check("nr_active", int'(nr_active_o), e.nr);
                check("err_no_sensor", int'(err_no_sensor_o), e.err);
                // cycle 1 is the one right after the edge that sampled start
                check("done_cycle", edge_cnt - e.start_edge + 1, e.cyc);
            end
        end
    end

    task automatic push_exp(input int q, input int r, input int nr, input int err,
                            input int cyc, input int start_edge);
        exp_t e;
        e.q = q; e.r = r; e.nr = nr; e.err = err; e.cyc = cyc; e.start_edge = start_edge;
        exp_q.push_back(e);
    endtask

    // Pulse start for one cycle with the given inputs and queue the expected result.
    task automatic run_pass(input logic [39:0] data, input logic [4:0] en,
                            input int q, input int r, input int nr, input int err, input int cyc);
        @(negedge clk_i);
        sensors_data_i = data;
        sensors_en_i   = en;
        start_i        = 1'b1;
        push_exp(q, r, nr, err, cyc, edge_cnt + 1);
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", int'(busy_o), 1);
    endtask

    task automatic wait_done(input int target, input string name);
        int budget = 100;
        while (done_seen < target && budget > 0) begin
            @(posedge clk_i);
            budget--;
        end
        @(negedge clk_i);
        check(name, int'(done_seen >= target), 1);
    endtask

    initial begin
        int d0;
        int s0;
        rst_i          = 1'b1;
        start_i        = 1'b0;
        sensors_data_i = 40'h0;
        sensors_en_i   = 5'b00000;
        repeat (3) @(negedge clk_i);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_q", int'(avg_q_o), 0);
        check("rst_r", int'(avg_r_o), 0);
        check("rst_nr", int'(nr_active_o), 0);
        check("rst_err", int'(err_no_sensor_o), 0);
        rst_i = 1'b0;

        run_pass(40'h13_12_15_19_14, 5'b11101, 19, 2, 4, 0, 22);
        wait_done(1, "timeout_mixed");

        run_pass(40'hFF_FF_FF_FF_FF, 5'b11111, 255, 0, 5, 0, 22);
        wait_done(2, "timeout_all_ff");
        repeat (3) @(negedge clk_i);
        check("hold_q", int'(avg_q_o), 255);
        check("hold_nr", int'(nr_active_o), 5);
        check("hold_busy", int'(busy_o), 0);

        run_pass(40'h13_12_15_19_14, 5'b00000, 0, 0, 0, 1, 6);
        wait_done(3, "timeout_zero");

        run_pass(40'h33_7B_AA_01_FF, 5'b01011, 126, 1, 3, 0, 22);
        wait_done(4, "timeout_remainder");

        // start held for 30 cycles: one pass, DONE cycle, IDLE, then a second pass
        @(negedge clk_i);
        sensors_data_i = 40'h07_55_55_55_55;
        sensors_en_i   = 5'b10000;
        start_i        = 1'b1;
        s0             = edge_cnt + 1;
        d0             = done_seen;
        push_exp(7, 0, 1, 0, 22, s0);
        push_exp(80, 0, 5, 0, 22, s0 + 23);
        @(negedge clk_i);
        sensors_data_i = 40'h50_50_50_50_50;
        sensors_en_i   = 5'b11111;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk_i);
            if (edge_cnt == s0 + 22) check("hold_idle_gap", int'(busy_o), 0);
        end
        start_i = 1'b0;
        check("hold_single_done", done_seen - d0, 1);
        wait_done(d0 + 2, "timeout_hold_second");

        // reset sampled at the edge closing cycle 10 of a pass
        @(negedge clk_i);
        sensors_data_i = 40'h13_12_15_19_14;
        sensors_en_i   = 5'b11101;
        start_i        = 1'b1;
        s0             = edge_cnt + 1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (edge_cnt < s0 + 9) @(negedge clk_i);
        rst_i = 1'b1;
        d0    = done_seen;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        check("abort_q", int'(avg_q_o), 0);
        check("abort_r", int'(avg_r_o), 0);
        check("abort_nr", int'(nr_active_o), 0);
        check("abort_err", int'(err_no_sensor_o), 0);
        repeat (30) @(negedge clk_i);
        check("abort_no_done", done_seen - d0, 0);

        run_pass(40'h13_12_15_19_14, 5'b11101, 19, 2, 4, 0, 22);
        wait_done(d0 + 1, "timeout_after_reset");

        repeat (5) @(negedge clk_i);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d edges, expected completion", edge_cnt);
        $fatal(1, "global timeout");
    end

endmodule
